// File: rtl/logic8_pkg.sv
// logic8_pkg: opcodes, FSM state encoding and requester count shared by the logic8 arbiter slice.
package logic8_pkg;
    localparam int NREQ = 4;
    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/logic8_unit.sv
// logic8_unit: combinational 8-bit bitwise logic unit (OR/AND/XOR/NOR) built on the 8-bit OR gate block.
module logic8_or8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y
);
    assign y = a | b;
endmodule

module logic8_unit
    import logic8_pkg::*;
(
    input  logic [1:0] op,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    output logic [7:0] out
);
    logic [7:0] or_y;
    logic8_or8 u_or (.a(in1), .b(in2), .y(or_y));
    // NOR reuses the OR block rather than a second gate array
    assign out = op == OP_OR  ? or_y :
                 op == OP_AND ? in1 & in2 :
                 op == OP_XOR ? in1 ^ in2 : ~or_y;
endmodule

// File: rtl/logic8_arbiter.sv
// logic8_arbiter: four-requester arbiter sharing one logic8_unit behind a valid/ready result.
// Define LOGIC8_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module logic8_arbiter
    import logic8_pkg::*;
#(
    parameter int W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [7:0]  op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [3:0]  gnt,
    output logic [7:0]  out,
    output logic [1:0]  out_id,
    output logic        out_valid,
    input  logic        out_ready
);
    state_t      state, state_nxt;
    logic [1:0]  win, id, opr;
    logic [7:0]  a, b, res;

`ifdef LOGIC8_ARB_RR_EN
    logic [1:0] ptr;
    // scan from the farthest offset down so the nearest request at/after ptr wins
    always_comb begin
        win = ptr;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[ptr + 2'(i)]) win = ptr + 2'(i);
    end
`else
    always_comb begin
        win = 2'd0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[i]) win = 2'(i);
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = |req ? EXEC : IDLE;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = out_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    logic8_unit u_unit (.op(opr), .in1(a), .in2(b), .out(res));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            out       <= '0;
            out_id    <= '0;
            out_valid <= 1'b0;
            id        <= '0;
            opr       <= '0;
            a         <= '0;
            b         <= '0;
`ifdef LOGIC8_ARB_RR_EN
            ptr       <= '0;
`endif
        end else begin
            state <= state_nxt;
            gnt   <= '0;
            if (state == IDLE && |req) begin
                gnt <= 4'b0001 << win;
                id  <= win;
                opr <= op[{win, 1'b0} +: 2];
                a   <= in1[{win, 3'b000} +: 8];
                b   <= in2[{win, 3'b000} +: 8];
`ifdef LOGIC8_ARB_RR_EN
                ptr <= win + 2'd1;
`endif
            end
            if (state == EXEC) begin
                out       <= res;
                out_id    <= id;
                out_valid <= 1'b1;
            end
            if (state == RESP && out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_logic8_arbiter.sv
// tb_logic8_arbiter: directed self-checking bench for logic8_arbiter (both LOGIC8_ARB_RR_EN builds).
module tb_logic8_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] in1, in2;
    logic [3:0]  gnt;
    logic [7:0]  out;
    logic [1:0]  out_id;
    logic        out_valid, out_ready;
    int checks = 0;
    int errors = 0;
    int ord [5];

    logic8_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .in1(in1), .in2(in2),
        .gnt(gnt), .out(out), .out_id(out_id), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        op[2*i +: 2]  = o;
        in1[8*i +: 8] = x;
        in2[8*i +: 8] = y;
        req = 4'b0001 << i;
    endtask

    task automatic run_op(input int i, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] exp, input string tag);
        set_req(i, o, x, y);
        tick();
        chk({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << i));
        req = 4'b0000;
        tick();
        chk({tag, "_out"}, 32'(out), 32'(exp));
        chk({tag, "_id"}, 32'(out_id), i);
        chk({tag, "_valid"}, 32'(out_valid), 1);
        tick();
        chk({tag, "_done"}, 32'(out_valid), 0);
    endtask

    initial begin
`ifdef LOGIC8_ARB_RR_EN
        ord = '{0, 1, 2, 3, 0};
`else
        ord = '{0, 0, 0, 0, 0};
`endif
        reset = 1'b1; req = '0; op = '0; in1 = '0; in2 = '0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_out", 32'(out), 0);
        chk("rst_id", 32'(out_id), 0);
        chk("rst_valid", 32'(out_valid), 0);

        set_req(0, 2'b00, 8'hA0, 8'h05);
        tick();
        chk("first_gnt", 32'(gnt), 32'h1);
        chk("first_valid_early", 32'(out_valid), 0);
        req = '0;
        tick();
        chk("first_gnt_clear", 32'(gnt), 0);
        chk("first_out", 32'(out), 32'hA5);
        chk("first_id", 32'(out_id), 0);
        chk("first_valid", 32'(out_valid), 1);
        tick();
        chk("first_valid_drop", 32'(out_valid), 0);

        run_op(2, 2'b00, 8'hCC, 8'hAA, 8'hEE, "or");
        run_op(2, 2'b01, 8'hCC, 8'hAA, 8'h88, "and");
        run_op(2, 2'b10, 8'hCC, 8'hAA, 8'h66, "xor");
        run_op(2, 2'b11, 8'hCC, 8'hAA, 8'h11, "nor");

        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("rr_gnt", 32'(gnt), 32'(4'b0001 << ord[n]));
            if (n == 4) req = '0;
            tick(); tick();
        end

        out_ready = 1'b0;
        set_req(0, 2'b10, 8'h3C, 8'h0F);
        op[3:2] = 2'b01; in1[15:8] = 8'hF0; in2[15:8] = 8'h3C;
        tick();
        chk("hold_gnt", 32'(gnt), 32'h1);
        req = 4'b0110;
        tick();
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("hold_out", 32'(out), 32'h33);
            chk("hold_id", 32'(out_id), 0);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_nognt", 32'(gnt), 0);
        end
        out_ready = 1'b1;
        tick();
        chk("hold_release", 32'(out_valid), 0);
        chk("hold_release_gnt", 32'(gnt), 0);
        tick();
        chk("after_ready_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick();
        chk("after_ready_out", 32'(out), 32'h30);
        chk("after_ready_id", 32'(out_id), 1);
        tick();

        set_req(2, 2'b00, 8'h0F, 8'h00);
        tick();
        chk("cap_gnt", 32'(gnt), 32'h4);
        in1[23:16] = 8'hFF;
        req = '0;
        tick();
        chk("cap_out", 32'(out), 32'h0F);
        tick();

        set_req(2, 2'b00, 8'h11, 8'h22);
        tick();
        chk("exec_rst_gnt", 32'(gnt), 32'h4);
        req = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("exec_rst_valid", 32'(out_valid), 0);
        chk("exec_rst_out", 32'(out), 0);
        chk("exec_rst_gnt0", 32'(gnt), 0);
        chk("exec_rst_id", 32'(out_id), 0);
        tick();
        chk("exec_rst_noresult", 32'(out_valid), 0);
        run_op(3, 2'b01, 8'hFF, 8'h5A, 8'h5A, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
